// File: rtl/uart_rx_pkg.sv
// uart_rx shared types: FSM state encoding, legal prescale values and parity types.
// Optional macro UART_RX_MAJORITY_SAMPLE_EN selects 3-sample majority voting in data_sampler.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef logic [5:0] prescale_t;

  localparam prescale_t PRESCALE_8  = 6'd8;
  localparam prescale_t PRESCALE_16 = 6'd16;
  localparam prescale_t PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Illegal factors are undefined; fold them onto a legal value so the
  // counters never run with a degenerate period.
  function automatic prescale_t legal_prescale(input prescale_t p);
    if ((p == PRESCALE_8) ||
        (p == PRESCALE_16) ||
        (p == PRESCALE_32)) begin
      return p;
    end
    return PRESCALE_16;
  endfunction

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) |
           (s[0] & s[2]) |
           (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// data_sampler: per-bit edge counter, mid-bit sampling and bit_end strobe.
// UART_RX_MAJORITY_SAMPLE_EN: vote over edge_cnt P/2-1, P/2, P/2+1 instead of one sample.
module data_sampler
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       rx_i,
  input  logic [5:0] prescale_i,
  output logic [5:0] edge_cnt_o,
  output logic       bit_o,
  output logic       bit_end_o
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;
  logic [5:0] last;
  logic [5:0] half;

  assign last      = prescale_i - 6'd1;
  assign half      = {1'b0, prescale_i[5:1]};
  assign bit_end_o = en_i && (cnt_q == last);
  assign edge_cnt_o = cnt_q;

  // Count 0..P-1 within each bit; park at 0 while idle.
  always_comb begin
    cnt_d = 6'd0;
    if (en_i && !bit_end_o) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Edge counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef UART_RX_MAJORITY_SAMPLE_EN
  logic [2:0] smp_q;

  // Capture three consecutive samples around the bit centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= 3'b000;
    end else begin
      if (cnt_q == half - 6'd1) smp_q[0] <= rx_i;
      if (cnt_q == half)        smp_q[1] <= rx_i;
      if (cnt_q == half + 6'd1) smp_q[2] <= rx_i;
    end
  end

  assign bit_o = majority3(smp_q);
`else
  logic smp_q;

  // Capture a single sample at the bit centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= 1'b0;
    end else if (cnt_q == half) begin
      smp_q <= rx_i;
    end
  end

  assign bit_o = smp_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and registered frame outputs.
// UART_RX_MAJORITY_SAMPLE_EN (in data_sampler) switches to majority-vote bit sampling.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BCW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT =
    BCW'(DATA_WIDTH - 1);

  state_e                state_q;
  state_e                state_d;
  logic [BCW-1:0]        bit_cnt_q;
  logic [BCW-1:0]        bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  par_err_q;
  logic                  par_err_d;
  logic                  stp_err_q;
  logic                  stp_err_d;
  logic                  bad_q;
  logic                  bad_d;
  prescale_t             presc_q;
  prescale_t             presc_d;
  logic                  par_en_q;
  logic                  par_en_d;
  logic                  par_typ_q;
  logic                  par_typ_d;

  logic [5:0] edge_cnt;
  logic       smp;
  logic       bit_end;
  logic       start_w;
  logic       cnt_en;
  logic       exp_par;

  // A fresh start edge only counts from a parked counter in IDLE.
  assign start_w = (state_q == IDLE) &&
                   (edge_cnt == 6'd0) &&
                   !RX_IN;
  assign cnt_en  = (state_q != IDLE) || start_w;
  assign exp_par = (^shift_q) ^ (par_typ_q == PAR_ODD);

  data_sampler u_sampler (
    .clk        (CLK),
    .rst_n      (RST),
    .en_i       (cnt_en),
    .rx_i       (RX_IN),
    .prescale_i (presc_q),
    .edge_cnt_o (edge_cnt),
    .bit_o      (smp),
    .bit_end_o  (bit_end)
  );

  // Frame FSM next-state: every non-IDLE state ends on bit_end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_w) state_d = START;
      end
      START: begin
        if (bit_end) state_d = smp ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt_q == LAST_BIT)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: config latch, shift-in, parity record, frame verdict.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    bad_d     = bad_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    unique case (state_q)
      IDLE: begin
        if (start_w) begin
          presc_d   = legal_prescale(Prescale);
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_cnt_d = '0;
          bad_d     = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {smp, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) bad_d = (smp != exp_par);
      end
      STOP: begin
        if (bit_end) begin
          valid_d   = !bad_q && smp;
          par_err_d = bad_q;
          stp_err_d = !smp;
          if (!bad_q && smp) data_d = shift_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      bad_q     <= 1'b0;
      presc_q   <= PRESCALE_8;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      bad_q     <= bad_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
    end
  end

  assign P_DATA     = data_q;
  assign DATA_VALID = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames against a line-level reference model.
// Honours UART_RX_MAJORITY_SAMPLE_EN to pick the expected sampling rule.
module tb_uart_rx;

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [5:0] presc;
  logic       pe;
  logic       pt;
  logic [7:0] p_data;
  logic       dv;
  logic       perr;
  logic       serr;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   ln[$];
  ev_t  evq[$];
  ev_t  expq[$];
  logic [7:0] pdata_m;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .RX_IN      (rx),
    .Prescale   (presc),
    .PAR_EN     (pe),
    .PAR_TYP    (pt),
    .P_DATA     (p_data),
    .DATA_VALID (dv),
    .PAR_ERR    (perr),
    .STP_ERR    (serr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (dv === 1'b1 || perr === 1'b1 || serr === 1'b1) begin
      ev_t e;
      e.cyc = cyc;
      e.dv  = dv;
      e.pe  = perr;
      e.se  = serr;
      e.d   = p_data;
      evq.push_back(e);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line image of one frame: P cycles per bit.
  task automatic build(input logic [7:0] d,
                       input int P,
                       input bit pen,
                       input bit pbit,
                       input bit sbit);
    int n;
    bit b;
    n = 10 + int'(pen);
    ln.delete();
    for (int k = 0; k < n; k++) begin
      if (k == 0)                b = 1'b0;
      else if (k <= 8)           b = d[k-1];
      else if (pen && k == 9)    b = pbit;
      else                       b = sbit;
      repeat (P) ln.push_back(b);
    end
  endtask

  function automatic int pick();
    case ($urandom_range(0, 2))
      0:       return 8;
      1:       return 16;
      default: return 32;
    endcase
  endfunction

  // Drive ln; config is valid on cycle 0, optionally garbage after.
  task automatic send(input int P,
                      input bit pen,
                      input bit ptyp,
                      input bit scr,
                      input int len,
                      output int start);
    start = cyc;
    for (int j = 0; j < len; j++) begin
      rx = ln[j];
      if (j == 0) begin
        presc = 6'(P);
        pe    = pen;
        pt    = ptyp;
      end else if (scr) begin
        presc = 6'(pick());
        pe    = 1'($urandom);
        pt    = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  function automatic bit samp(input int k, input int P);
    int m;
    m = k * P + P / 2;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
    return (int'(ln[m-1]) + int'(ln[m]) + int'(ln[m+1])) >= 2;
`else
    return ln[m];
`endif
  endfunction

  // Reference: decode the line image bit by bit and predict the verdict.
  task automatic model_push(input int start,
                            input int P,
                            input bit pen,
                            input bit ptyp);
    int n;
    logic [7:0] dm;
    bit bad;
    bit stop;
    ev_t x;
    n = 10 + int'(pen);
    if (samp(0, P)) return;
    for (int i = 0; i < 8; i++) dm[i] = samp(1 + i, P);
    bad  = pen && (samp(9, P) != ((^dm) ^ ptyp));
    stop = samp(9 + int'(pen), P);
    if (!bad && stop) pdata_m = dm;
    x.cyc = start + n * P;
    x.dv  = !bad && stop;
    x.pe  = bad;
    x.se  = !stop;
    x.d   = pdata_m;
    expq.push_back(x);
  endtask

  task automatic expect_ev(input int c, input logic v,
                           input logic pr, input logic sr,
                           input logic [7:0] d);
    ev_t x;
    x.cyc = c;
    x.dv  = v;
    x.pe  = pr;
    x.se  = sr;
    x.d   = d;
    expq.push_back(x);
  endtask

  task automatic check_all(input string tag);
    ev_t e;
    ev_t x;
    idle(6);
    chk({tag, "_events"}, evq.size(), expq.size());
    while (evq.size() > 0 && expq.size() > 0) begin
      e = evq.pop_front();
      x = expq.pop_front();
      chk({tag, "_cycle"}, e.cyc, x.cyc);
      chk({tag, "_valid"}, {31'd0, e.dv}, {31'd0, x.dv});
      chk({tag, "_parerr"}, {31'd0, e.pe}, {31'd0, x.pe});
      chk({tag, "_stperr"}, {31'd0, e.se}, {31'd0, x.se});
      chk({tag, "_pdata"}, {24'd0, e.d}, {24'd0, x.d});
    end
    evq.delete();
    expq.delete();
  endtask

  initial begin
    int s;
    int s2;
    int P;
    int idx;
    bit pen;
    bit ptyp;
    bit pbit;
    bit sbit;
    logic [7:0] d;
    logic [7:0] flip_exp;

    rst_n = 1'b1;
    rx    = 1'b1;
    presc = 6'd8;
    pe    = 1'b0;
    pt    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pdata", {24'd0, p_data}, 32'd0);
    chk("reset_valid", {31'd0, dv}, 32'd0);
    chk("reset_parerr", {31'd0, perr}, 32'd0);
    chk("reset_stperr", {31'd0, serr}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, P=8, even parity.
    build(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    send(8, 1'b1, 1'b0, 1'b0, ln.size(), s);
    expect_ev(s + 88, 1'b1, 1'b0, 1'b0, 8'hA5);
    check_all("good");

    // Same frame, wrong parity bit.
    build(8'hA5, 8, 1'b1, 1'b1, 1'b1);
    send(8, 1'b1, 1'b0, 1'b0, ln.size(), s);
    expect_ev(s + 88, 1'b0, 1'b1, 1'b0, 8'hA5);
    check_all("parerr");

    // Stop bit low, P=16, no parity.
    build(8'h5A, 16, 1'b0, 1'b0, 1'b0);
    send(16, 1'b0, 1'b0, 1'b0, ln.size(), s);
    expect_ev(s + 160, 1'b0, 1'b0, 1'b1, 8'hA5);
    check_all("stperr");

    // Glitch of 3 cycles; next frame starts exactly in cycle 16.
    ln.delete();
    repeat (3) ln.push_back(1'b0);
    repeat (13) ln.push_back(1'b1);
    send(16, 1'b0, 1'b0, 1'b0, ln.size(), s);
    build(8'h81, 16, 1'b0, 1'b0, 1'b1);
    send(16, 1'b0, 1'b0, 1'b0, ln.size(), s2);
    chk("glitch_gap", s2 - s, 16);
    expect_ev(s2 + 160, 1'b1, 1'b0, 1'b0, 8'h81);
    check_all("glitch");

    // Back-to-back frames at P=32.
    build(8'h3C, 32, 1'b0, 1'b0, 1'b1);
    send(32, 1'b0, 1'b0, 1'b0, ln.size(), s);
    build(8'hC3, 32, 1'b0, 1'b0, 1'b1);
    send(32, 1'b0, 1'b0, 1'b0, ln.size(), s2);
    expect_ev(s + 320, 1'b1, 1'b0, 1'b0, 8'h3C);
    expect_ev(s2 + 320, 1'b1, 1'b0, 1'b0, 8'hC3);
    check_all("b2b");

    // One-cycle inversion at the centre of data bit 3.
`ifdef UART_RX_MAJORITY_SAMPLE_EN
    flip_exp = 8'h5A;
`else
    flip_exp = 8'h52;
`endif
    build(8'h5A, 16, 1'b0, 1'b0, 1'b1);
    ln[4 * 16 + 8] = ~ln[4 * 16 + 8];
    send(16, 1'b0, 1'b0, 1'b0, ln.size(), s);
    expect_ev(s + 160, 1'b1, 1'b0, 1'b0, flip_exp);
    check_all("flip");

    // Reset in the middle of the data bits.
    build(8'h96, 8, 1'b0, 1'b0, 1'b1);
    send(8, 1'b0, 1'b0, 1'b0, 40, s);
    rst_n = 1'b0;
    #2;
    chk("midrst_pdata", {24'd0, p_data}, 32'd0);
    chk("midrst_valid", {31'd0, dv}, 32'd0);
    chk("midrst_parerr", {31'd0, perr}, 32'd0);
    chk("midrst_stperr", {31'd0, serr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk("midrst_noevent", evq.size(), 0);
    build(8'h69, 8, 1'b0, 1'b0, 1'b1);
    send(8, 1'b0, 1'b0, 1'b0, ln.size(), s);
    expect_ev(s + 80, 1'b1, 1'b0, 1'b0, 8'h69);
    check_all("postrst");
    pdata_m = 8'h69;

    // Random frames with config churn, bad bits and stray inversions.
    for (int f = 0; f < 24; f++) begin
      P    = pick();
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      d    = 8'($urandom);
      pbit = (^d) ^ ptyp;
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      sbit = ($urandom_range(0, 3) != 0);
      build(d, P, pen, pbit, sbit);
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(P, ln.size() - 1);
        ln[idx] = ~ln[idx];
      end
      send(P, pen, ptyp, 1'b1, ln.size(), s);
      model_push(s, P, pen, ptyp);
      idle($urandom_range(0, 3));
    end
    check_all("rand");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver. It is the downstream counterpart of the UART transmitter: it consumes the serial line the transmitter drives (start bit 0, DATA_WIDTH data bits LSB first, optional parity, stop bit 1). It oversamples each bit with a programmable prescale, checks the frame, and delivers the received word with a one-cycle valid pulse to the system-side consumer.

## Interface
Parameters:
- DATA_WIDTH, default 8: data bits per frame and width of P_DATA.

Ports:
- CLK  input  1: receiver oversampling clock. The block uses this single clock only.
- RST  input  1: asynchronous, active-low reset.
- RX_IN  input  1: serial line. It is already synchronous to CLK; the block contains no synchronizer. It idles at 1.
- Prescale  input  6: oversampling factor P. Legal values are 8, 16 and 32. Any other value gives undefined behaviour.
- PAR_EN  input  1: 1 = a parity bit follows the data.
- PAR_TYP  input  1: 0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH: last good received word.
- DATA_VALID  output  1: one-cycle pulse when P_DATA is updated.
- PAR_ERR  output  1: one-cycle pulse at the end of a frame with a parity mismatch.
- STP_ERR  output  1: one-cycle pulse at the end of a frame whose stop bit sampled 0.

## Operation
- State machine states: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state lasts exactly P cycles, counted by edge_cnt from 0 to P-1.
- Transitions:
  - IDLE: when RX_IN=0, go to START. Latch Prescale, PAR_EN and PAR_TYP. This detection cycle is edge_cnt 0 of the start bit.
  - START: at edge_cnt P-1, go to DATA if the sampled bit is 0. Otherwise the event is a glitch: go to IDLE and assert no outputs.
  - DATA: the sampled bit shifts in LSB first, and bit_cnt increments at each edge_cnt P-1. After bit DATA_WIDTH-1, go to PARITY if PAR_EN is latched, else go to STOP.
  - PARITY: at edge_cnt P-1, compare the sampled bit with the computed parity (XOR of the data word, inverted when PAR_TYP=1). Record any mismatch. Go to STOP.
  - STOP: at edge_cnt P-1, go to IDLE and evaluate the frame.
- Frame evaluation takes effect on the cycle after STOP edge_cnt P-1:
  - DATA_VALID=1 and P_DATA loaded only if there is no parity mismatch and the stop bit is 1.
  - PAR_ERR=1 if there is a mismatch.
  - STP_ERR=1 if the stop bit is 0.
  - Both error pulses may assert in the same cycle.
  - On any error, P_DATA holds its previous value.
- Sampling point: the bit value is the single sample at edge_cnt P/2 (see Configuration for the majority-vote alternative).
- Prescale, PAR_EN and PAR_TYP are ignored outside IDLE. Changes to them mid-frame have no effect until the next frame.
- Back-to-back frames: the cycle after STOP is spent in IDLE, so a start bit beginning immediately after the stop bit is detected with no lost cycles.
- Reset, including reset asserted mid-frame: state goes to IDLE, and all counters, P_DATA, DATA_VALID, PAR_ERR and STP_ERR go to 0.

## Timing
- Frame length is N = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- With the start-detection cycle numbered 0, DATA_VALID, PAR_ERR and STP_ERR assert in cycle N*P, for exactly one cycle.
- The earliest next frame start is detected in cycle N*P.
- A glitch returns the block to IDLE in cycle P.
- Outputs are fully registered. There is no combinational path from RX_IN to any output.

## Configuration
- Macro UART_RX_MAJORITY_SAMPLE_EN.
  - Defined: the bit value is the majority of the samples at edge_cnt P/2-1, P/2 and P/2+1.
  - Undefined: the bit value is the single sample at P/2.
- Frame timing and output cycles are identical in both builds.

## Structure
- Shared package uart_rx_pkg holds:
  - the state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - the legal prescale constants (8, 16, 32);
  - the parity type constants (EVEN=0, ODD=1).
- One sub-module, data_sampler, holds edge_cnt and the sampling registers. It outputs edge_cnt, the sampled bit, and a bit_end strobe at edge_cnt P-1. The macro affects only this sub-module.

## Test plan
- Good frame: P=8, PAR_EN=1, PAR_TYP=0, byte 0xA5 (line sequence 0,1,0,1,0,0,1,0,1, parity 0, stop 1). Required response: DATA_VALID in cycle 88, P_DATA=0xA5, no error pulses.
- Parity error: the same frame with parity bit 1. Required response: PAR_ERR pulse in cycle 88, no DATA_VALID, P_DATA keeps its previous value.
- Stop error: P=16, PAR_EN=0, byte 0x5A, stop bit 0. Required response: STP_ERR in cycle 160, no DATA_VALID, P_DATA unchanged.
- Glitch: P=16, RX_IN low for 3 cycles, then high. Required response: return to IDLE in cycle 16, no output pulses. A valid frame sent afterwards is received correctly.
- Back-to-back frames: P=32, PAR_EN=0, frames 0x3C then 0xC3 with no idle gap. Required response: DATA_VALID pulses exactly 320 cycles apart, with P_DATA 0x3C then 0xC3.
- Sampling and reset:
  - With the macro defined, a single-cycle inversion at edge_cnt P/2 of data bit 3 leaves the received byte correct. Without the macro, bit 3 is flipped.
  - RST asserted during DATA returns all outputs to 0, and the next frame is received cleanly.
